// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the BCD scan counter: count requests and load in,
// registered count, wrap pulse and scanned digit/select out.
interface bcd_scan_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  carry;
  logic [3:0]            digit;
  logic [DIGITS-1:0]     dsel;

  modport master (
    output en, up, load, load_val,
    input  count, carry, digit, dsel
  );

  modport slave (
    input  en, up, load, load_val,
    output count, carry, digit, dsel
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed digit scanner.
// Define BCD_SCAN_BLANK_EN to blank leading zeros on dsel.
module bcd_scan_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input logic               clk,
  input logic               rst,
  bcd_scan_counter_if.slave bus
);
  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    load_clean;
  logic [W-1:0]    step_val;
  logic            wrap;
  logic            carry_q;
  logic [DivW-1:0] div_q;
  logic [IdxW-1:0] idx_q;
  logic [DIGITS-1:0] onehot;

  // Out-of-range load digits become 0 so the decoder never sees codes 10..15.
  always_comb begin
    load_clean = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd0;
      end else begin
        load_clean[4*i +: 4] = bus.load_val[4*i +: 4];
      end
    end
  end

  // wrap stays set while every digit so far rolls over; after the top digit it
  // flags a full-range wrap.
  always_comb begin
    step_val = count_q;
    wrap     = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (wrap) begin
        if (bus.up) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            wrap               = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            wrap               = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = load_clean;
    end else if (bus.en) begin
      count_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
    end else begin
      count_q <= count_d;
      carry_q <= bus.en & ~bus.load & wrap;
      if (div_q == DivLast) begin
        div_q <= '0;
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign onehot    = DIGITS'(1) << idx_q;
  assign bus.count = count_q;
  assign bus.carry = carry_q;
  assign bus.digit = count_q[4*idx_q +: 4];

`ifdef BCD_SCAN_BLANK_EN
  logic blank;

  // Blank when the scanned digit and all above it are zero; digit 0 always shows.
  always_comb begin
    blank = (idx_q != '0);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i >= int'(idx_q) && count_q[4*i +: 4] != 4'd0) begin
        blank = 1'b0;
      end
    end
  end

  assign bus.dsel = blank ? '0 : onehot;
`else
  assign bus.dsel = onehot;
`endif
endmodule
